// File: rtl/bram_arbiter_if.sv
// bram_arbiter_if: requester handshakes and BRAM port of the two-requester BRAM arbiter
interface bram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              b_tb;
    logic              b_wren;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data_i;
    logic [DATA_W-1:0] b_data_o;
    logic              busy;

    // environment side: the two requesters plus the BRAM itself
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, b_data_o,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  b_tb, b_wren, b_addr, b_data_i, busy
    );

    // arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, b_data_o,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output b_tb, b_wren, b_addr, b_data_i, busy
    );
endinterface

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter sharing one single-port BRAM between two requesters.
// Optional BRAM_ARB_SCRUB_EN: zero the whole BRAM after reset before any grant.
module bram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    bram_arbiter_if.slave bus
);
    typedef enum logic {SCRUB, RUN} state_t;
`ifdef BRAM_ARB_SCRUB_EN
    localparam state_t START = SCRUB;
    logic [ADDR_W-1:0] scrub_q, scrub_d;
`else
    localparam state_t START = RUN;
`endif
    state_t            state_q, state_d;
    logic              pri_q, pri_d;
    logic              b_tb_q, b_tb_d;
    logic              b_wren_q, b_wren_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_data_i_q, b_data_i_d;
    logic              s1_v_q, s1_v_d, s1_id_q, s1_id_d;
    logic              s2_v_q, s2_v_d, s2_id_q, s2_id_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              run, gnt0, gnt1, hs, we_sel, rvalid0, rvalid1;

    // grants: pri_q names the requester that wins a tie; nothing is granted in reset or scrub
    always_comb begin
        run     = rst_n && state_q == RUN;
        gnt0    = run && bus.req0 && (!bus.req1 || !pri_q);
        gnt1    = run && bus.req1 && (!bus.req0 || pri_q);
        hs      = gnt0 || gnt1;
        we_sel  = gnt0 ? bus.we0 : bus.we1;
        rvalid0 = s2_v_q && !s2_id_q;
        rvalid1 = s2_v_q && s2_id_q;
    end

    // next state: BRAM command register, read-tag pipeline, held read data, scrub walk
    always_comb begin
        state_d    = state_q;
        pri_d      = gnt0 ? 1'b1 : gnt1 ? 1'b0 : pri_q;
        b_tb_d     = hs;
        b_wren_d   = hs && we_sel;
        b_addr_d   = gnt0 ? bus.addr0 : gnt1 ? bus.addr1 : b_addr_q;
        b_data_i_d = gnt0 ? bus.wdata0 : gnt1 ? bus.wdata1 : b_data_i_q;
        s1_v_d     = hs && !we_sel;
        s1_id_d    = gnt1;
        s2_v_d     = s1_v_q;
        s2_id_d    = s1_id_q;
        rdata0_d   = rvalid0 ? bus.b_data_o : rdata0_q;
        rdata1_d   = rvalid1 ? bus.b_data_o : rdata1_q;
`ifdef BRAM_ARB_SCRUB_EN
        scrub_d    = scrub_q;
        if (state_q == SCRUB) begin
            b_tb_d     = 1'b1;
            b_wren_d   = 1'b1;
            b_addr_d   = scrub_q;
            b_data_i_d = '0;
            scrub_d    = scrub_q + 1'b1;
            state_d    = &scrub_q ? RUN : SCRUB;
        end
`endif
    end

    // state registers; reset drops in-flight read tags and restarts any scrub
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= START;
            pri_q      <= 1'b0;
            b_tb_q     <= 1'b0;
            b_wren_q   <= 1'b0;
            b_addr_q   <= '0;
            b_data_i_q <= '0;
            s1_v_q     <= 1'b0;
            s1_id_q    <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_id_q    <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef BRAM_ARB_SCRUB_EN
            scrub_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pri_q      <= pri_d;
            b_tb_q     <= b_tb_d;
            b_wren_q   <= b_wren_d;
            b_addr_q   <= b_addr_d;
            b_data_i_q <= b_data_i_d;
            s1_v_q     <= s1_v_d;
            s1_id_q    <= s1_id_d;
            s2_v_q     <= s2_v_d;
            s2_id_q    <= s2_id_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifdef BRAM_ARB_SCRUB_EN
            scrub_q    <= scrub_d;
`endif
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rvalid0  = rvalid0;
    assign bus.rvalid1  = rvalid1;
    assign bus.rdata0   = rvalid0 ? bus.b_data_o : rdata0_q;
    assign bus.rdata1   = rvalid1 ? bus.b_data_o : rdata1_q;
    assign bus.b_tb     = b_tb_q;
    assign bus.b_wren   = b_wren_q;
    assign bus.b_addr   = b_addr_q;
    assign bus.b_data_i = b_data_i_q;
`ifdef BRAM_ARB_SCRUB_EN
    assign bus.busy     = rst_n && state_q == SCRUB;
`else
    assign bus.busy     = 1'b0;
`endif
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: self-checking bench for bram_arbiter with a BRAM model and a transaction-level reference
module tb_bram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if bus ();
    bram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // single-port BRAM: read data appears the cycle after the strobe
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] dout = 32'h0;
    assign bus.b_data_o = dout;
    always @(posedge clk) begin
        if (bus.b_tb) begin
            if (bus.b_wren) mem[bus.b_addr] <= bus.b_data_i;
            else dout <= mem[bus.b_addr];
        end
    end

    // reference: shadow memory, tie-break owner, expected BRAM command, queue of pending read returns
    typedef struct {int due; bit id; logic [31:0] data;} rd_t;
    rd_t         q[$];
    logic [31:0] ref_mem [256] = '{default: 32'h0};
    bit          fav;
    bit          m_tb, m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_data, m_rd0, m_rd1;
    int          total = 0, bad = 0, cyc = 0;
    bit          x_g0, x_g1, s_rv0, s_rv1;
    logic [31:0] s_rd0, s_rd1;

    typedef struct {bit r0; bit r1; bit w0; bit w1; logic [7:0] a0; logic [7:0] a1; bit g0; bit g1;} vec_t;
    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        fav = 1'b0; m_tb = 1'b0; m_we = 1'b0; m_addr = 8'h0; m_data = 32'h0;
        m_rd0 = 32'h0; m_rd1 = 32'h0;
        q.delete();
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [7:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [7:0] a1, input logic [31:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    // one clock cycle: drive at a falling edge, check 1 ns later, advance the reference, wait for next falling edge
    task automatic cycle(input bit r0, input bit w0, input logic [7:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [7:0] a1, input logic [31:0] d1);
        rd_t h;
        bit e_rv0, e_rv1, id, we;
        logic [7:0] a;
        logic [31:0] d;
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        #1;
        x_g0 = r0 && (!r1 || !fav);
        x_g1 = r1 && (!r0 || fav);
        chk("gnt0", bus.gnt0, x_g0);
        chk("gnt1", bus.gnt1, x_g1);
        chk("busy", bus.busy, 0);
        chk("b_tb", bus.b_tb, m_tb);
        chk("b_wren", bus.b_wren, m_we);
        chk("b_addr", bus.b_addr, m_addr);
        chk("b_data_i", bus.b_data_i, m_data);
        e_rv0 = 1'b0;
        e_rv1 = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            h = q.pop_front();
            if (h.id) begin e_rv1 = 1'b1; m_rd1 = h.data; end
            else begin e_rv0 = 1'b1; m_rd0 = h.data; end
        end
        s_rv0 = bus.rvalid0; s_rv1 = bus.rvalid1; s_rd0 = bus.rdata0; s_rd1 = bus.rdata1;
        chk("rvalid0", s_rv0, e_rv0);
        chk("rvalid1", s_rv1, e_rv1);
        chk("rdata0", s_rd0, m_rd0);
        chk("rdata1", s_rd1, m_rd1);
        if (x_g0 || x_g1) begin
            id = x_g1;
            we = id ? w1 : w0;
            a = id ? a1 : a0;
            d = id ? d1 : d0;
            fav = !id;
            m_tb = 1'b1; m_we = we; m_addr = a; m_data = d;
            if (we) ref_mem[a] = d;
            else q.push_back('{cyc + 2, id, ref_mem[a]});
        end else begin
            m_tb = 1'b0;
            m_we = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
    endtask

    // reset for two cycles starting at the current falling edge; outputs must all be 0 while held
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1, 0, 8'h33, 32'h1, 1, 1, 8'h44, 32'h2);
        #1;
        chk("rst gnt0", bus.gnt0, 0);
        chk("rst gnt1", bus.gnt1, 0);
        chk("rst rvalid0", bus.rvalid0, 0);
        chk("rst rvalid1", bus.rvalid1, 0);
        chk("rst rdata0", bus.rdata0, 0);
        chk("rst rdata1", bus.rdata1, 0);
        chk("rst b_tb", bus.b_tb, 0);
        chk("rst b_wren", bus.b_wren, 0);
        chk("rst b_addr", bus.b_addr, 0);
        chk("rst b_data_i", bus.b_data_i, 0);
        chk("rst busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        drive(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
        rst_n = 1'b1;
        model_reset();
`ifdef BRAM_ARB_SCRUB_EN
        begin
            int n;
            n = 0;
            for (int k = 0; k < 300; k++) begin
                #1;
                if (!bus.busy) break;
                if (k > 0) begin
                    chk("scrub b_tb", bus.b_tb, 1);
                    chk("scrub b_wren", bus.b_wren, 1);
                    chk("scrub b_addr", bus.b_addr, k - 1);
                    chk("scrub b_data_i", bus.b_data_i, 0);
                end
                n++;
                @(negedge clk);
            end
            chk("scrub busy cycles", n, 256);
            chk("scrub last b_tb", bus.b_tb, 1);
            chk("scrub last b_addr", bus.b_addr, 255);
            @(negedge clk);
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
            m_addr = 8'hFF;
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit p0, p1, w0, w1;
        logic [7:0] a0, a1;
        logic [31:0] d0, d1;
        tv[0]  = '{1, 1, 1, 1, 8'h20, 8'h21, 1, 0};
        tv[1]  = '{0, 1, 0, 1, 8'h20, 8'h21, 0, 1};
        tv[2]  = '{1, 1, 0, 0, 8'h20, 8'h21, 1, 0};
        tv[3]  = '{1, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        tv[4]  = '{1, 1, 0, 0, 8'h20, 8'h21, 1, 0};
        tv[5]  = '{1, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        tv[6]  = '{0, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        tv[7]  = '{0, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        tv[8]  = '{0, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        tv[9]  = '{1, 1, 0, 0, 8'h20, 8'h21, 1, 0};
        tv[10] = '{0, 0, 0, 0, 8'h20, 8'h21, 0, 0};
        tv[11] = '{1, 0, 0, 0, 8'h20, 8'h21, 1, 0};
        tv[12] = '{1, 1, 0, 0, 8'h20, 8'h21, 0, 1};
        model_reset();
        drive(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
        @(negedge clk);
        do_reset();

        // arbitration table straight out of reset: first-cycle grant, alternation, round-robin recovery
        for (int i = 0; i < 13; i++) begin
            cycle(tv[i].r0, tv[i].w0, tv[i].a0, {24'hC0FFEE, tv[i].a0},
                  tv[i].r1, tv[i].w1, tv[i].a1, {24'hC0FFEE, tv[i].a1});
            chk($sformatf("table%0d gnt0", i), bus.gnt0 === 1'bx ? 1'b0 : x_g0, tv[i].g0);
            chk($sformatf("table%0d gnt1", i), x_g1, tv[i].g1);
        end
        idle(3);

        // single-requester write then read-back
        cycle(1, 1, 8'h05, 32'hDEADBEEF, 0, 0, 8'h0, 32'h0);
        chk("wr05 gnt0", x_g0, 1);
        cycle(1, 0, 8'h05, 32'h0, 0, 0, 8'h0, 32'h0);
        chk("rd05 gnt0", x_g0, 1);
        cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
        chk("rd05 no early rvalid0", s_rv0, 0);
        cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
        chk("rd05 rvalid0", s_rv0, 1);
        chk("rd05 rdata0", s_rd0, 32'hDEADBEEF);
        idle(2);

        // reset one cycle after a read handshake: the read must never return
        cycle(1, 1, 8'h80, 32'h12345678, 0, 0, 8'h0, 32'h0);
        cycle(0, 0, 8'h0, 32'h0, 1, 1, 8'h10, 32'hA5A5A5A5);
        cycle(0, 0, 8'h0, 32'h0, 1, 0, 8'h10, 32'h0);
        do_reset();
        idle(4);

        // read 0x80: cleared by the scrub when enabled, otherwise it keeps the earlier write
        cycle(1, 0, 8'h80, 32'h0, 0, 0, 8'h0, 32'h0);
        idle(1);
        cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
        chk("rd80 rvalid0", s_rv0, 1);
`ifdef BRAM_ARB_SCRUB_EN
        chk("rd80 rdata0", s_rd0, 32'h0);
`else
        chk("rd80 rdata0", s_rd0, 32'h12345678);
`endif

        // random traffic: each requester holds its request until the reference says it was granted
        p0 = 1'b0; p1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        a0 = 8'h0; a1 = 8'h0; d0 = 32'h0; d1 = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; w0 = 1'($urandom_range(0, 1)); a0 = 8'($urandom_range(0, 15)); d0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; w1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom_range(0, 15)); d1 = $urandom;
            end
            cycle(p0, w0, a0, d0, p1, w1, a1, d1);
            if (x_g0) p0 = 1'b0;
            if (x_g1) p1 = 1'b0;
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 8: BRAM address width (256 words).
- REQ-002 Parameter DATA_W, default 32: BRAM data width.
- REQ-003 clock  input  1  sole clock; all state updates on rising edge.
- REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
- REQ-005 reqN  input  1  request from requester N (N = 0, 1).
- REQ-006 weN  input  1  1 = write, 0 = read, for requester N.
- REQ-007 addrN  input  ADDR_W  word address from requester N.
- REQ-008 wdataN  input  DATA_W  write data from requester N.
- REQ-009 gntN  output  1  grant to requester N; the transfer occurs when reqN and gntN are both high.
- REQ-010 rvalidN  output  1  one-cycle pulse; rdataN is valid for requester N's read.
- REQ-011 rdataN  output  DATA_W  read data for requester N.
- REQ-012 b_tb  output  1  BRAM access strobe.
- REQ-013 b_wren  output  1  BRAM write enable.
- REQ-014 b_addr  output  ADDR_W  BRAM address.
- REQ-015 b_data_i  output  DATA_W  BRAM write data.
- REQ-016 b_data_o  input  DATA_W  BRAM read data, valid one cycle after the strobe cycle.
- REQ-017 busy  output  1  high while the arbiter is initialising the memory; no grants are issued.

Function
- REQ-018 The block SHALL drive gntN combinationally from reqN, arbitration state and busy, and SHALL never assert gnt0 and gnt1 together.
- REQ-019 With a single requester active and busy low, that requester SHALL be granted in the same cycle.
- REQ-020 With both requesters active, the block SHALL grant the requester not served last (round robin); the last-served pointer SHALL update only on a handshake.
- REQ-021 A requester SHALL hold reqN, weN, addrN and wdataN stable until granted; the arbiter SHALL sustain one handshake per cycle.
- REQ-022 A handshake in cycle T SHALL register b_tb=1, b_addr=addrN, b_wren=weN and b_data_i=wdataN, visible in cycle T+1.
- REQ-023 If no handshake occurs in cycle T, b_tb and b_wren SHALL be 0 in cycle T+1; b_addr and b_data_i hold their previous values.
- REQ-024 For a read handshake in cycle T, the block SHALL pulse rvalidN in cycle T+2, with rdataN = b_data_o sampled in that cycle.
- REQ-025 rdataN SHALL hold its value between pulses; writes SHALL never raise rvalidN.
- REQ-026 The block SHALL keep an in-flight tag per pipeline stage so that back-to-back reads from alternating requesters return data to the correct requester in order.
- REQ-027 The state machine SHALL have two states: SCRUB (busy=1) and RUN (busy=0). RUN is terminal until reset.

Reset
- REQ-028 While reset is low, the block SHALL force: gnt0/1=0, rvalid0/1=0, rdata0/1=0, b_tb=0, b_wren=0, b_addr=0, b_data_i=0, in-flight tags cleared, round-robin pointer favouring requester 0.
- REQ-029 Reset asserted mid-operation SHALL discard in-flight reads (no rvalid pulse) and abort any scrub in progress.
- REQ-030 After reset deasserts, the block SHALL enter SCRUB when BRAM_ARB_SCRUB_EN is defined, and RUN otherwise.

Configuration
- REQ-031 Macro BRAM_ARB_SCRUB_EN defined: SCRUB SHALL write 0 to addresses 0..2^ADDR_W-1 in ascending order, one per cycle, with b_tb=1 and b_wren=1.
- REQ-032 With BRAM_ARB_SCRUB_EN defined, the block SHALL enter RUN after the last address (255) is written; the first grant is possible in the cycle after the final scrub strobe; a reset during scrub SHALL restart the scrub from address 0.
- REQ-033 Macro BRAM_ARB_SCRUB_EN undefined: no scrub logic; busy SHALL be constant 0; the block SHALL be in RUN from the first cycle after reset.

Verification
- REQ-034 Reset low for 2 cycles, then high (scrub on) -> busy high for exactly 256 cycles; b_addr runs 0..255 with b_wren=1 and b_data_i=0; a subsequent read of addr 0x80 returns 0.
- REQ-035 req0 write addr 0x05 data 0xDEADBEEF, then req0 read addr 0x05 -> gnt0 in the same cycle; rvalid0 at T+2 with rdata0=0xDEADBEEF.
- REQ-036 req0 and req1 held high for 4 cycles, all reads -> grants alternate 0,1,0,1; each rvalid goes only to its owner, in order.
- REQ-037 req1 alone for 3 cycles -> gnt1 every cycle; then both requesters high -> requester 0 granted next.
- REQ-038 Read of addr 0x10 granted, reset pulsed low in cycle T+1 -> no rvalid pulse; all outputs are 0 during reset.
- REQ-039 Build without BRAM_ARB_SCRUB_EN -> busy=0 always; req0 granted in the first cycle after reset deasserts.
